// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared FSM states and size helpers for the GF(2^M) digit-serial multiplier
package gf2m_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int ceil_div(input int x, input int y);
    return (x + y - 1) / y;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gf2m_digit_step.sv
// gf2m_digit_step: one digit step, reduce((acc*x^D) ^ (a*digit)) mod f(x)
module gf2m_digit_step #(
  parameter int M = 40,
  parameter int D = 8,
  parameter logic [M-1:0] POLY = 40'h0000000039
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  output logic [M-1:0] nxt
);
  localparam logic [M+D-1:0] F = (M+D)'({1'b1, POLY});
  logic [M+D-1:0] s;
  logic [M+D-1:0] ax;
  always_comb begin
    ax = (M+D)'(a);
    s = {acc, {D{1'b0}}};
    for (int i = 0; i < D; i++) s = digit[i] ? s ^ (ax << i) : s;
    for (int j = D - 1; j >= 0; j--) s = s[M+j] ? s ^ (F << j) : s;
    nxt = s[M-1:0];
  end
endmodule

// File: rtl/gf2m_digit_mult.sv
// gf2m_digit_mult: digit-serial GF(2^M) polynomial-basis multiplier, MSD first, valid/ready both sides
module gf2m_digit_mult
  import gf2m_pkg::*;
#(
  parameter int M = 40,
  parameter int D = 8,
  parameter logic [M-1:0] POLY = 40'h0000000039
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] c
);
  localparam int N = ceil_div(M, D);
  localparam int CW = cnt_w(N);
  state_t state, nxt_state;
  logic [M-1:0] acc, a_q, acc_nxt;
  logic [N*D-1:0] b_q;
  logic [CW-1:0] cnt;
  logic [D-1:0] digit;
  assign digit = b_q[D*int'(cnt) +: D];
  gf2m_digit_step #(.M(M), .D(D), .POLY(POLY)) u_step (
    .acc(acc),
    .a(a_q),
    .digit(digit),
    .nxt(acc_nxt)
  );
  always_comb begin
    nxt_state = state == IDLE ? (in_valid ? RUN : IDLE)
              : state == RUN  ? (cnt == '0 ? DONE : RUN)
              : (out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    out_valid = state == DONE;
    c = acc;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
    end else begin
      state <= nxt_state;
      if (state == IDLE && in_valid) begin
        a_q <= a;
        b_q <= (N*D)'(b);
        acc <= '0;
        cnt <= CW'(N - 1);
      end else if (state == RUN) begin
        acc <= acc_nxt;
        cnt <= cnt == '0 ? cnt : cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_gf2m_digit_mult.sv
// tb_gf2m_digit_mult: checks AES (D=4), non-dividing (D=3) and default (M=40) configs against a bit-serial model
module tb_gf2m_digit_mult;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic [7:0] a8 [2];
  logic [7:0] b8 [2];
  logic [7:0] c8 [2];
  logic iv8 [2];
  logic ir8 [2];
  logic ov8 [2];
  logic or8 [2];
  logic [39:0] a40, b40, c40;
  logic iv40, ir40, ov40, or40;

  gf2m_digit_mult #(.M(8), .D(4), .POLY(8'h1B)) u_aes (
    .clk(clk), .reset(rst_n), .in_valid(iv8[0]), .in_ready(ir8[0]), .a(a8[0]), .b(b8[0]),
    .out_valid(ov8[0]), .out_ready(or8[0]), .c(c8[0]));
  gf2m_digit_mult #(.M(8), .D(3), .POLY(8'h1B)) u_nd (
    .clk(clk), .reset(rst_n), .in_valid(iv8[1]), .in_ready(ir8[1]), .a(a8[1]), .b(b8[1]),
    .out_valid(ov8[1]), .out_ready(or8[1]), .c(c8[1]));
  gf2m_digit_mult u_def (
    .clk(clk), .reset(rst_n), .in_valid(iv40), .in_ready(ir40), .a(a40), .b(b40),
    .out_valid(ov40), .out_ready(or40), .c(c40));

  // Bit-serial Horner reference: r = r*x mod f, then add a when b_i is set
  function automatic logic [63:0] gmul(input logic [63:0] x, input logic [63:0] y, input int m, input logic [63:0] p);
    logic [63:0] r;
    r = 0;
    for (int i = m - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[m]) r = r ^ p ^ (64'd1 << m);
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input int k, input logic [7:0] av, input logic [7:0] bv, output logic [7:0] cv, output int lat);
    a8[k] = av; b8[k] = bv; iv8[k] = 1; or8[k] = 1;
    tick();
    iv8[k] = 0;
    lat = 0;
    while (!ov8[k] && lat < 50) begin tick(); lat++; end
    cv = c8[k];
    tick();
  endtask

  task automatic run40(input logic [39:0] av, input logic [39:0] bv, output logic [39:0] cv, output int lat);
    a40 = av; b40 = bv; iv40 = 1; or40 = 1;
    tick();
    iv40 = 0;
    lat = 0;
    while (!ov40 && lat < 50) begin tick(); lat++; end
    cv = c40;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    iv8[0] = 1; iv8[1] = 1; iv40 = 1;
    a8[0] = 8'h57; b8[0] = 8'h83; a8[1] = 8'h57; b8[1] = 8'h83; a40 = 40'h2; b40 = 40'h1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checks++; if (ir8[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", k, ir8[k]); end
      checks++; if (ov8[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", k, ov8[k]); end
      checks++; if (c8[k] !== 8'h00) begin errors++; $display("FAIL reset_c[%0d] got=%h exp=00", k, c8[k]); end
    end
    checks++; if (ir40 !== 1'b1 || ov40 !== 1'b0 || c40 !== 40'h0) begin errors++; $display("FAIL reset_def got ir=%b ov=%b c=%h exp ir=1 ov=0 c=0", ir40, ov40, c40); end
    iv8[0] = 0; iv8[1] = 0; iv40 = 0;
    rst_n = 1;
    tick();
    checks++; if (ir8[0] !== 1'b1 || ir40 !== 1'b1) begin errors++; $display("FAIL post_reset_idle got aes=%b def=%b exp=1", ir8[0], ir40); end
  endtask

  task automatic test_aes();
    logic [7:0] cv, av, bv, e;
    int lat;
    run8(0, 8'h57, 8'h83, cv, lat);
    checks++; if (cv !== 8'hC1) begin errors++; $display("FAIL aes_57x83 got=%h exp=c1", cv); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL aes_latency got=%0d exp=2", lat); end
    run8(0, 8'h57, 8'h13, cv, lat);
    checks++; if (cv !== 8'hFE) begin errors++; $display("FAIL aes_57x13 got=%h exp=fe", cv); end
    for (int i = 0; i < 40; i++) begin
      av = 8'($urandom); bv = i == 0 ? 8'h01 : i == 1 ? 8'h00 : 8'($urandom);
      e = 8'(gmul(64'(av), 64'(bv), 8, 64'h1B));
      run8(0, av, bv, cv, lat);
      checks++; if (cv !== e) begin errors++; $display("FAIL aes_rand %h*%h got=%h exp=%h", av, bv, cv, e); end
    end
  endtask

  task automatic test_nondiv();
    logic [7:0] cv, av, bv, e;
    int lat;
    run8(1, 8'h57, 8'h83, cv, lat);
    checks++; if (cv !== 8'hC1) begin errors++; $display("FAIL nd_57x83 got=%h exp=c1", cv); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL nd_latency got=%0d exp=3", lat); end
    for (int i = 0; i < 40; i++) begin
      av = 8'($urandom); bv = 8'($urandom);
      e = 8'(gmul(64'(av), 64'(bv), 8, 64'h1B));
      run8(1, av, bv, cv, lat);
      checks++; if (cv !== e) begin errors++; $display("FAIL nd_rand %h*%h got=%h exp=%h", av, bv, cv, e); end
    end
  endtask

  task automatic test_defaults();
    logic [39:0] cv, av, bv, e;
    int lat;
    run40(40'h2, 40'h1 << 39, cv, lat);
    checks++; if (cv !== 40'h0000000039) begin errors++; $display("FAIL def_x_times_x39 got=%h exp=0000000039", cv); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL def_latency got=%0d exp=5", lat); end
    run40(40'h0, 40'hFFFFFFFFFF, cv, lat);
    checks++; if (cv !== 40'h0) begin errors++; $display("FAIL def_zero got=%h exp=0", cv); end
    run40(40'hA5A5A5A5A5, 40'h1, cv, lat);
    checks++; if (cv !== 40'hA5A5A5A5A5) begin errors++; $display("FAIL def_one got=%h exp=a5a5a5a5a5", cv); end
    for (int i = 0; i < 1000; i++) begin
      av = 40'({$urandom, $urandom}); bv = 40'({$urandom, $urandom});
      e = 40'(gmul(64'(av), 64'(bv), 40, 64'h39));
      run40(av, bv, cv, lat);
      checks++; if (cv !== e || lat !== 5) begin errors++; $display("FAIL def_rand %h*%h got=%h lat=%0d exp=%h lat=5", av, bv, cv, lat, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] hold, e;
    int lat;
    a8[0] = 8'h57; b8[0] = 8'h83; iv8[0] = 1; or8[0] = 0;
    tick();
    iv8[0] = 0;
    lat = 0;
    while (!ov8[0] && lat < 50) begin tick(); lat++; end
    hold = c8[0];
    checks++; if (hold !== 8'hC1 || lat !== 2) begin errors++; $display("FAIL bp_first got=%h lat=%0d exp=c1 lat=2", hold, lat); end
    a8[0] = 8'hCA; b8[0] = 8'h53; iv8[0] = 1;
    repeat (7) begin
      tick();
      checks++; if (c8[0] !== 8'hC1 || ov8[0] !== 1'b1 || ir8[0] !== 1'b0) begin errors++; $display("FAIL bp_hold got c=%h ov=%b ir=%b exp c=c1 ov=1 ir=0", c8[0], ov8[0], ir8[0]); end
    end
    or8[0] = 1;
    tick();
    checks++; if (ir8[0] !== 1'b1 || ov8[0] !== 1'b0) begin errors++; $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", ir8[0], ov8[0]); end
    tick();
    checks++; if (ir8[0] !== 1'b0) begin errors++; $display("FAIL bp_next_accept got ir=%b exp=0", ir8[0]); end
    iv8[0] = 0;
    lat = 0;
    while (!ov8[0] && lat < 50) begin tick(); lat++; end
    e = 8'(gmul(64'hCA, 64'h53, 8, 64'h1B));
    checks++; if (c8[0] !== e || lat !== 2) begin errors++; $display("FAIL bp_second got=%h lat=%0d exp=%h lat=2", c8[0], lat, e); end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [7:0] cv;
    int lat;
    int seen;
    a8[0] = 8'h12; b8[0] = 8'h34; iv8[0] = 1; or8[0] = 1;
    a40 = 40'h123456789A; b40 = 40'hFEDCBA9876; iv40 = 1; or40 = 1;
    tick();
    iv8[0] = 0; iv40 = 0;
    tick();
    rst_n = 0;
    #1;
    checks++; if (ir8[0] !== 1'b1 || ov8[0] !== 1'b0 || c8[0] !== 8'h00) begin errors++; $display("FAIL midrst_aes got ir=%b ov=%b c=%h exp ir=1 ov=0 c=00", ir8[0], ov8[0], c8[0]); end
    tick();
    tick();
    rst_n = 1;
    seen = 0;
    repeat (8) begin tick(); if (ov8[0] || ov40) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_output got=%0d cycles with out_valid exp=0", seen); end
    checks++; if (ir40 !== 1'b1 || c40 !== 40'h0) begin errors++; $display("FAIL midrst_def got ir=%b c=%h exp ir=1 c=0", ir40, c40); end
    run8(0, 8'h57, 8'h83, cv, lat);
    checks++; if (cv !== 8'hC1 || lat !== 2) begin errors++; $display("FAIL midrst_recover got=%h lat=%0d exp=c1 lat=2", cv, lat); end
  endtask

  initial begin
    iv8[0] = 0; iv8[1] = 0; iv40 = 0;
    or8[0] = 1; or8[1] = 1; or40 = 1;
    a8[0] = 0; a8[1] = 0; b8[0] = 0; b8[1] = 0; a40 = 0; b40 = 0;
    test_reset();
    test_aes();
    test_nondiv();
    test_defaults();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gf2m_digit_mult.md
# gf2m_digit_mult

Parametrised digit-serial multiplier over GF(2^M) in polynomial basis. It is the successor to the fixed 5×8-bit two-stage multiplier in the ECC datapath. It computes C = A·B mod f(x) for configurable field degree M, digit width D and reduction polynomial. The block processes one D-bit digit of B per cycle, MSD first, and uses valid/ready handshakes on both sides so the point-arithmetic sequencer can stall it.

## Interface
- `M`, default 40: field degree; width of A, B and C.
- `D`, default 8: digit width; legal range 1 ≤ D ≤ M.
- `POLY`, default 40'h0000000039: f(x) without its x^M term. Default encodes x^40+x^5+x^4+x^3+1.
- `N`, derived and not overridable: ceil(M/D), the number of compute cycles.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands on `a`/`b` are valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  M  multiplicand, bit i = coefficient of x^i.
- `b`  in  M  multiplier, same encoding.
- `out_valid`  out  1  `c` holds a finished product.
- `out_ready`  in  1  consumer accepts `c`.
- `c`  out  M  product A·B mod f(x).

## Operation
- **States**
  - IDLE: `in_ready`=1.
  - RUN: computing.
  - DONE: `out_valid`=1.
- **IDLE→RUN** on `in_valid`&&`in_ready`:
  - Latch A into `a_q`.
  - Latch B zero-extended to N·D bits into `b_q`.
  - Clear `acc` to 0 and load `cnt`=N-1.
- **RUN, every cycle**, with digit = `b_q[cnt·D +: D]`:
  - `acc` ← reduce((`acc`·x^D) ⊕ (`a_q`·digit)).
  - `·` is carry-less polynomial multiply; the sum is M+D bits wide.
  - reduce folds the top D bits from MSB down. For each set bit at position M+j, XOR `POLY`<<j into the low bits and clear that bit. The result is correct for any `POLY`.
  - If `cnt`==0, go to DONE; otherwise `cnt`←`cnt`-1.
- **DONE**: `c`=`acc`. When `out_valid`&&`out_ready`, go to IDLE.
- `c` is driven from `acc` at all times. It is meaningful only while `out_valid`=1.
- `in_valid` is ignored outside IDLE. Operand inputs are sampled only on the accept edge and may change afterwards.
- `out_ready` is ignored outside DONE.
- B=0 or A=0 gives C=0. B=1 gives C=A. The result is already reduced because A and B are in canonical form.
- If A or B has a coefficient ≥ x^M, this is unrepresentable and cannot occur.
- When D does not divide M, the zero-padded top digit of B contributes nothing. The result is still exact.

## Timing
- **Reset** (`reset`=0, asynchronous):
  - State=IDLE.
  - `acc`, `a_q`, `b_q`, `cnt` = 0.
  - `in_ready`=1, `out_valid`=0, `c`=0.
- **Reset mid-operation**: any in-flight product is discarded with no output. After release, the block is in IDLE on the next edge.
- **Latency**: accept on edge k gives `out_valid` high after edge k+N. With defaults N=5, so `out_valid` rises 5 cycles after accept.
- **Back-pressure**: `out_valid` and `c` hold stable until accepted.
- **Throughput**: minimum accept-to-accept interval is N+2 cycles (accept, N RUN edges, output handshake, return to IDLE).
- **Outputs**: `in_ready` and `out_valid` are registered-state decodes with no combinational path from inputs.
- **Edge case**: D=M gives N=1, a single RUN cycle.

## Structure
- **Package `gf2m_pkg`**:
  - state enum {IDLE, RUN, DONE}.
  - `ceil_div` function used to derive N.
  - `clog2`-based width for `cnt`, max(1, clog2(N)).
- **Sub-module `gf2m_digit_step`** (combinational, parameters M, D, POLY):
  - Inputs: `acc`, `a`, `digit`.
  - Output: the next `acc`.
  - Contains the carry-less multiply and the fold reduction.
- The top level holds the FSM, counter and registers.

## Test plan
- **Reset**: hold `reset`=0 for 3 cycles, pulse `in_valid` during reset → `in_ready`=1, `out_valid`=0, `c`=0. Nothing is accepted.
- **AES field** (M=8, D=4, POLY=8'h1B):
  - A=8'h57, B=8'h83 → `c`=8'hC1 with `out_valid` 2 cycles after accept.
  - A=8'h57, B=8'h13 → `c`=8'hFE.
- **Non-dividing digit** (M=8, D=3, POLY=8'h1B): A=8'h57, B=8'h83 → `c`=8'hC1 after 3 cycles.
- **Defaults** (M=40):
  - A=40'h2 (x), B=1<<39 → `c`=40'h0000000039.
  - A=0, B=40'hFFFFFFFFFF → `c`=0.
  - Also check against a bit-serial software model for 1000 random pairs.
- **Back-pressure**: hold `out_ready`=0 for 7 cycles; `in_valid` stays 1 with new operands → `c` stable, `in_ready`=0. On release, the handshake completes, and the next accept occurs exactly one cycle later.
- **Reset mid-RUN**: assert `reset`=0 two cycles after accept → `out_valid` never rises. The next operation (A=8'h57, B=8'h83, AES config) still returns 8'hC1.
